uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter for the Basys3 USB-UART path. Accepts words on a valid/ready write port into an internal FIFO and serialises them LSB-first onto `o_tx`. Data width, parity mode, stop-bit count, baud divisor and buffer depth are configurable. The FIFO lets bursts go out back-to-back with no idle gap between frames.

## Interface
- `CLKS_PER_BIT`, 10416: clock cycles per serial bit; each bit lasts exactly this many cycles; legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: buffer entries; power of 2, ≥2.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_data`  in  DATA_BITS  word to enqueue.
- `i_valid`  in  1  write request; a word is accepted on an edge where `i_valid && o_ready`.
- `o_ready`  out  1  FIFO not full; `o_fifo_count != FIFO_DEPTH`.
- `o_tx`  out  1  serial line; idle high.
- `o_busy`  out  1  frame in progress or FIFO non-empty.
- `o_fifo_count`  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
- `o_overflow`  out  1  one-cycle pulse: `i_valid` high while FIFO full; the word is dropped.

## Operation
- FIFO: circular buffer with wrapping read/write pointers and a registered count.
  - Write when `i_valid && o_ready`.
  - Pop when the FSM starts a frame.
  - Simultaneous write and pop leaves the count unchanged.
  - `o_ready` is derived from the registered count. When full, a write is refused even if a pop happens on the same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `o_tx = 1`. If count > 0: pop the head into the shift register, drive `o_tx <= 0`, clear the baud counter, go to START.
  - START: after `CLKS_PER_BIT` cycles, drive data bit 0 and go to DATA.
  - DATA: shift LSB-first. After `DATA_BITS` bit periods, go to PARITY if `PARITY != 0`, else drive 1 and go to STOP.
  - PARITY: drive the parity bit for one bit period.
    - Odd: the total count of 1s across data and parity is odd.
    - Even: the total is even.
    - Parity is computed from the popped word, not the live shift register.
  - STOP: `o_tx = 1` for `STOP_BITS` bit periods. On the final cycle:
    - if the FIFO is non-empty, pop and enter START directly (no idle cycle);
    - otherwise return to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 only while not in IDLE. The bit advances when the count reaches `CLKS_PER_BIT`-1, then the counter wraps to 0. No free-running tick, so there is no phase jitter on frame start.
- Frame length is exactly `CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)` cycles.
- `o_busy = (state != IDLE) || (count != 0)`.
- `o_overflow` is registered: high for the one cycle after an edge where `i_valid && !o_ready`.

## Timing
- Reset values: `o_tx=1`, `o_ready=1`, `o_busy=0`, `o_fifo_count=0`, `o_overflow=0`, state IDLE, pointers 0.
- Reset mid-frame: `o_tx` returns high immediately (asynchronously), the FIFO is flushed, and the partial frame is lost.
- Write to an idle, empty block, accepted at edge E0:
  - `o_fifo_count=1` and `o_busy=1` after E0.
  - At E1: pop, `o_tx` falls, count returns to 0.
  - Start-bit latency from the accepting edge is 1 cycle.
- The data bit k transition occurs at E1 + (k+1)·`CLKS_PER_BIT`.
- Back-to-back frames: the next start bit falls on the edge immediately after the last stop-bit cycle.
- Pointer wrap-around at `FIFO_DEPTH` is transparent, and the count never exceeds `FIFO_DEPTH`.
- `o_ready` and `o_fifo_count` update on the edge following a write or pop; there is no combinational path from `i_valid`.

## Test plan
- **8N1 single word.** `CLKS_PER_BIT=4`, 8N1, write 0xA5 → `o_tx` is low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles; `o_busy` drops after the last stop cycle.
- **Back-to-back burst.** 8N1, `CLKS_PER_BIT=4`, write 0x01, 0x02, 0x03 on consecutive cycles → three 40-cycle frames with no idle gap. `o_fifo_count` peaks at 2.
- **Even parity, 2 stop bits.** 7-bit data, even parity, 2 stop bits, write 0x55 → data 1,0,1,0,1,0,1, parity 0, two stop bits. Frame is 11 bit periods.
- **Odd parity, 9 data bits.** Write 0x1FF → parity bit 0 (nine 1s is already odd). Write 0x000 → parity bit 1.
- **Overflow.** `FIFO_DEPTH=16`, hold `i_valid` for 18 cycles with an incrementing word → 17 words accepted (16 buffered plus 1 popped at E1). `o_overflow` pulses once and the 18th word is absent from the output stream.
- **Reset mid-frame.** Assert `i_rst` during data bit 3 with 4 words queued → `o_tx=1`, count 0 and `o_busy=0` immediately. After release, a new word transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  uart_tx_fifo : buffered UART transmitter, FIFO front end, LSB-first serialiser
//  Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_BW = $clog2(CLKS_PER_BIT);
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
  localparam logic [c_AW:0]   c_FULL      = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wptr;
  logic [c_AW-1:0]      r_rptr;
  logic [c_AW:0]        r_count;
  logic                 r_ovf;

  state_t               r_state;
  logic                 r_tx;
  logic [c_BW-1:0]      r_baud;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr;
  logic                 w_pop;
  logic                 w_baud_end;
  logic                 w_stop_end;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_par;

  assign w_full     = (r_count == c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_wr       = i_valid && !w_full;
  assign w_baud_end = (r_baud == c_BAUD_LAST);
  assign w_stop_end = (r_state == S_STOP) && w_baud_end && (r_bitcnt == c_STOP_LAST);
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_stop_end);
  assign w_head     = r_mem[r_rptr];
  // Parity is latched from the popped word so the shifting register never feeds it.
  assign w_par      = (PARITY == 1) ? ~(^w_head) : (^w_head);

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= i_valid && w_full;
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= w_par;
            r_tx    <= 1'b0;
            r_baud  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitcnt <= '0;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            if (r_bitcnt == c_DATA_LAST) begin
              r_bitcnt <= '0;
              if (PARITY != 0) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_baud_end) begin
            r_tx     <= 1'b1;
            r_bitcnt <= '0;
            r_state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            if (r_bitcnt == c_STOP_LAST) begin
              r_bitcnt <= '0;
              // A queued word starts its frame on this edge, leaving no idle gap.
              if (w_pop) begin
                r_shift <= w_head;
                r_par   <= w_par;
                r_tx    <= 1'b0;
                r_state <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx         = r_tx;
  assign o_ready      = !w_full;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  tb_uart_tx_fifo : scoreboard bench for uart_tx_fifo in 8N1, 7E2 and 9O1 builds
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int c_CPB  [3] = '{4, 4, 3};
  localparam int c_DB   [3] = '{8, 7, 9};
  localparam int c_PAR  [3] = '{0, 2, 1};
  localparam int c_STOP [3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] d0 = '0;
  logic [6:0] d1 = '0;
  logic [8:0] d2 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       bsy0, bsy1, bsy2;
  logic [4:0] cnt0, cnt1, cnt2;
  logic       ovf0, ovf1, ovf2;

  int n_chk = 0;
  int n_err = 0;
  int sb0[$];
  int sb1[$];
  int sb2[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_data(d0), .i_valid(v0), .o_ready(rdy0),
    .o_tx(tx0), .o_busy(bsy0), .o_fifo_count(cnt0), .o_overflow(ovf0));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(d1), .i_valid(v1), .o_ready(rdy1),
    .o_tx(tx1), .o_busy(bsy1), .o_fifo_count(cnt1), .o_overflow(ovf1));

  uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_data(d2), .i_valid(v2), .o_ready(rdy2),
    .o_tx(tx2), .o_busy(bsy2), .o_fifo_count(cnt2), .o_overflow(ovf2));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic void sb_push(input int sel, input int d);
    case (sel)
      0:       sb0.push_back(d);
      1:       sb1.push_back(d);
      default: sb2.push_back(d);
    endcase
  endfunction

  function automatic int sb_size(input int sel);
    case (sel)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic int sb_pop(input int sel);
    case (sel)
      0:       return sb0.pop_front();
      1:       return sb1.pop_front();
      default: return sb2.pop_front();
    endcase
  endfunction

  // Reference frame: start, data LSB first, optional parity, stop bits.
  task automatic build_frame(input int sel, input int d, output logic [15:0] fr, output int len);
    int ones;
    ones = 0;
    fr   = '1;
    len  = 0;
    fr[len++] = 1'b0;
    for (int i = 0; i < c_DB[sel]; i++) begin
      fr[len++] = 1'((d >> i) & 1);
      ones += (d >> i) & 1;
    end
    if (c_PAR[sel] == 1) fr[len++] = ((ones % 2) == 0);
    if (c_PAR[sel] == 2) fr[len++] = ((ones % 2) == 1);
    for (int i = 0; i < c_STOP[sel]; i++) fr[len++] = 1'b1;
  endtask

  // Receives nfr frames, checking every cycle of every bit period.
  task automatic rx_frames(input int sel, input int nfr, input int first_wait, input bit no_gap);
    logic [15:0] fr;
    int          len;
    int          t;
    int          exp;
    for (int f = 0; f < nfr; f++) begin
      t = 0;
      while (get_tx(sel) !== 1'b0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (t >= 400) begin
        chk_eq("start_timeout", 32'(t), 32'd0);
        return;
      end
      if (f == 0 && first_wait >= 0) chk_eq("start_latency", 32'(t), 32'(first_wait));
      if (f > 0 && no_gap) chk_eq("frame_gap", 32'(t), 32'd0);
      if (sb_size(sel) == 0) begin
        chk_eq("sb_empty", 32'd0, 32'd1);
        return;
      end
      exp = sb_pop(sel);
      build_frame(sel, exp, fr, len);
      for (int b = 0; b < len; b++) begin
        for (int c = 0; c < c_CPB[sel]; c++) begin
          chk_eq($sformatf("tx_s%0d_w%0h_b%0d", sel, exp, b), 32'(get_tx(sel)), 32'(fr[b]));
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic wr(input int sel, input int d);
    case (sel)
      0:       begin v0 = 1'b1; d0 = 8'(d); end
      1:       begin v1 = 1'b1; d1 = 7'(d); end
      default: begin v2 = 1'b1; d2 = 9'(d); end
    endcase
    sb_push(sel, d);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_pulses;
    repeat (3) @(negedge clk);
    chk_eq("rst_tx", 32'(tx0), 32'd1);
    chk_eq("rst_ready", 32'(rdy0), 32'd1);
    chk_eq("rst_busy", 32'(bsy0), 32'd0);
    chk_eq("rst_count", 32'(cnt0), 32'd0);
    chk_eq("rst_ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("idle_tx", 32'(tx0), 32'd1);

    // 8N1 single word
    wr(0, 8'hA5);
    chk_eq("single_count", 32'(cnt0), 32'd1);
    chk_eq("single_busy", 32'(bsy0), 32'd1);
    rx_frames(0, 1, 1, 1'b0);
    chk_eq("single_busy_end", 32'(bsy0), 32'd0);
    chk_eq("single_count_end", 32'(cnt0), 32'd0);

    // back-to-back burst
    fork
      begin
        for (int i = 1; i <= 3; i++) begin
          v0 = 1'b1;
          d0 = 8'(i);
          sb_push(0, i);
          @(negedge clk);
        end
        v0 = 1'b0;
        chk_eq("burst_peak", 32'(cnt0), 32'd2);
      end
      rx_frames(0, 3, -1, 1'b1);
    join
    chk_eq("burst_busy_end", 32'(bsy0), 32'd0);

    // 7 data bits, even parity, 2 stop bits
    wr(1, 7'h55);
    rx_frames(1, 1, 1, 1'b0);
    chk_eq("e2_busy_end", 32'(bsy1), 32'd0);

    // 9 data bits, odd parity
    fork
      begin
        wr(2, 9'h1FF);
        wr(2, 9'h000);
      end
      rx_frames(2, 2, -1, 1'b1);
    join
    chk_eq("o1_busy_end", 32'(bsy2), 32'd0);

    // overflow: 18 cycles of writes into a 16-deep buffer
    ovf_pulses = 0;
    fork
      begin
        for (int k = 0; k < 18; k++) begin
          v0 = 1'b1;
          d0 = 8'(8'h40 + k);
          if (k < 17) sb_push(0, 8'h40 + k);
          @(negedge clk);
          ovf_pulses += int'(ovf0);
        end
        v0 = 1'b0;
        chk_eq("ovf_full_count", 32'(cnt0), 32'd16);
        chk_eq("ovf_ready_low", 32'(rdy0), 32'd0);
        repeat (3) begin
          @(negedge clk);
          ovf_pulses += int'(ovf0);
        end
        chk_eq("ovf_pulses", 32'(ovf_pulses), 32'd1);
      end
      rx_frames(0, 17, -1, 1'b1);
    join
    chk_eq("ovf_dropped_word", 32'(bsy0), 32'd0);
    chk_eq("ovf_sb_drained", 32'(sb0.size()), 32'd0);

    // reset during data bit 3
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1;
      d0 = 8'(i * 8'h11);
      @(negedge clk);
    end
    v0 = 1'b0;
    repeat (15) @(negedge clk);
    chk_eq("pre_rst_tx", 32'(tx0), 32'd0);
    chk_eq("pre_rst_count", 32'(cnt0), 32'd3);
    rst = 1'b1;
    #1;
    chk_eq("async_rst_tx", 32'(tx0), 32'd1);
    chk_eq("async_rst_count", 32'(cnt0), 32'd0);
    chk_eq("async_rst_busy", 32'(bsy0), 32'd0);
    chk_eq("async_rst_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    sb0.delete();
    @(negedge clk);
    wr(0, 8'h5A);
    rx_frames(0, 1, 1, 1'b0);
    chk_eq("post_rst_busy", 32'(bsy0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
